// File: rtl/alu_seq_if.sv
// Request/response bus between the CPU datapath and the nibble-serial ALU sequencer.
// master = CPU side issuing requests, slave = alu_seq.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;

  modport master (
    output req_valid, req_op, req_wide, req_a, req_b, req_carry, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_wide, req_a, req_b, req_carry, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_seq.sv
// Nibble-serial ALU sequencer: drives a combinational 4-bit ALU core one nibble per
// clock with a chained carry, then presents the assembled result and Z/N/H/C flags.
module alu_seq (
  input  logic       clock,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [3:0] nib_a,
  output logic [3:0] nib_b,
  output logic [2:0] nib_op,
  output logic       nib_cin,
  input  logic [3:0] nib_out,
  input  logic       nib_cout
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic        r_wide;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_cy_in;
  logic [1:0]  r_k;
  logic [15:0] r_res;
  logic        r_carry;
  logic        r_h;
  logic        r_c;

  logic w_is_logic;
  logic w_is_sub;
  logic w_last;
  logic w_h_nib;

  assign w_is_logic = (r_op == OP_AND) || (r_op == OP_XOR) || (r_op == OP_OR);
  assign w_is_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
  assign w_last     = r_wide ? (r_k == 2'd3) : (r_k == 2'd1);
  // Half carry comes from bit 3 on byte ops and bit 11 on word ops.
  assign w_h_nib    = r_wide ? (r_k == 2'd2) : (r_k == 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: a default assignment precedes the case so no path leaves w_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.req_valid) w_next = S_RUN;
      S_RUN:  if (w_last)        w_next = S_RESP;
      S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op    <= '0;
      r_wide  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_cy_in <= 1'b0;
      r_k     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_h     <= 1'b0;
      r_c     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_op    <= bus.req_op;
          r_wide  <= bus.req_wide;
          r_a     <= bus.req_wide ? bus.req_a : {8'h00, bus.req_a[7:0]};
          r_b     <= bus.req_wide ? bus.req_b : {8'h00, bus.req_b[7:0]};
          r_cy_in <= bus.req_carry;
          r_k     <= '0;
          r_res   <= '0;
          r_carry <= 1'b0;
          r_h     <= 1'b0;
          r_c     <= 1'b0;
        end
        S_RUN: begin
          r_res[{r_k, 2'b00} +: 4] <= nib_out;
          r_carry                  <= nib_cout;
          r_k                      <= r_k + 2'd1;
          if (w_h_nib) r_h <= nib_cout;
          if (w_last)  r_c <= nib_cout;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_result = '0;
    bus.rsp_flags  = '0;
    nib_a          = '0;
    nib_b          = '0;
    nib_op         = '0;
    nib_cin        = 1'b0;
    case (r_state)
      S_IDLE: bus.req_ready = 1'b1;
      S_RUN: begin
        nib_a = r_a[{r_k, 2'b00} +: 4];
        nib_b = r_b[{r_k, 2'b00} +: 4];
        if (w_is_logic) begin
          nib_op = r_op;
        end else if (r_k == 2'd0) begin
          case (r_op)
            OP_ADC: begin nib_op = OP_ADC; nib_cin = r_cy_in; end
            OP_SBC: begin nib_op = OP_SBC; nib_cin = r_cy_in; end
            OP_SUB, OP_CP: nib_op = OP_SUB;
            default:       nib_op = OP_ADD;
          endcase
        end else begin
          nib_op  = w_is_sub ? OP_SBC : OP_ADC;
          nib_cin = r_carry;
        end
      end
      S_RESP: begin
        bus.rsp_valid  = 1'b1;
        // cp reports the untouched first operand; its flags still come from the subtraction.
        bus.rsp_result = (r_op == OP_CP) ? r_a : r_res;
        bus.rsp_flags  = {(r_res == 16'h0000),
                          w_is_sub,
                          (r_op == OP_AND) ? 1'b1 : (w_is_logic ? 1'b0 : r_h),
                          w_is_logic ? 1'b0 : r_c};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 4-bit ALU core and hand-computed results.
module tb_alu_seq;

  logic       clock;
  logic       reset;
  logic [3:0] nib_a, nib_b, nib_out;
  logic [2:0] nib_op;
  logic       nib_cin, nib_cout;
  logic [4:0] core_tmp;

  int n_total = 0;
  int n_bad   = 0;

  alu_seq_if bus ();

  alu_seq dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .nib_a    (nib_a),
    .nib_b    (nib_b),
    .nib_op   (nib_op),
    .nib_cin  (nib_cin),
    .nib_out  (nib_out),
    .nib_cout (nib_cout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core model: cout is carry for add/adc, borrow for sub/sbc, 0 for logic ops.
  always_comb begin
    core_tmp = 5'd0;
    case (nib_op)
      3'd0: core_tmp = {1'b0, nib_a} + {1'b0, nib_b};
      3'd1: core_tmp = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, nib_cin};
      3'd2: core_tmp = {1'b0, nib_a} - {1'b0, nib_b};
      3'd3: core_tmp = {1'b0, nib_a} - {1'b0, nib_b} - {4'd0, nib_cin};
      3'd4: core_tmp = {1'b0, nib_a & nib_b};
      3'd5: core_tmp = {1'b0, nib_a ^ nib_b};
      3'd6: core_tmp = {1'b0, nib_a | nib_b};
      default: core_tmp = 5'd0;
    endcase
    nib_out  = core_tmp[3:0];
    nib_cout = core_tmp[4];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic wide,
                        input logic [15:0] a, input logic [15:0] b, input logic cy,
                        input logic [2:0] e_op0, input logic e_cin0,
                        input logic [15:0] e_res, input logic [3:0] e_flg, input int hold);
    int n;
    bus.req_op    = op;
    bus.req_wide  = wide;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_carry = cy;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    // Scramble the request inputs: captured operands must not follow them.
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    bus.req_b     = 16'h5A5A;
    bus.req_op    = ~op;
    bus.req_carry = ~cy;
    bus.req_wide  = ~wide;
    check({tag, ":rdy_run"}, 32'(bus.req_ready), 32'd0);
    check({tag, ":nib_op0"}, 32'(nib_op), 32'(e_op0));
    check({tag, ":nib_cin0"}, 32'(nib_cin), 32'(e_cin0));
    check({tag, ":nib_a0"}, 32'(nib_a), 32'(a[3:0]));
    check({tag, ":nib_b0"}, 32'(nib_b), 32'(b[3:0]));
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, ":latency"}, 32'(n), wide ? 32'd4 : 32'd2);
    check({tag, ":result"}, 32'(bus.rsp_result), 32'(e_res));
    check({tag, ":flags"}, 32'(bus.rsp_flags), 32'(e_flg));
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      @(posedge clock); #1;
      check({tag, ":hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, ":hold_result"}, 32'(bus.rsp_result), 32'(e_res));
      check({tag, ":hold_flags"}, 32'(bus.rsp_flags), 32'(e_flg));
      check({tag, ":hold_rdy"}, 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    check({tag, ":rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ":rdy_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_wide  = 1'b0;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h4321;
    bus.req_carry = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    check("rst:req_ready", 32'(bus.req_ready), 32'd1);
    check("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst:result", 32'(bus.rsp_result), 32'd0);
    check("rst:flags", 32'(bus.rsp_flags), 32'd0);
    check("rst:nib_a", 32'(nib_a), 32'd0);
    check("rst:nib_b", 32'(nib_b), 32'd0);
    check("rst:nib_op", 32'(nib_op), 32'd0);
    check("rst:nib_cin", 32'(nib_cin), 32'd0);
    // rsp_ready while idle must have no effect.
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
    check("rst_win:req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_win:rsp_valid", 32'(bus.rsp_valid), 32'd0);

    //     tag         op    wide  a         b         cy    op0   cin0  result    flags    hold
    run_op("add8",     3'd0, 1'b0, 16'h003A, 16'h00C6, 1'b0, 3'd0, 1'b0, 16'h0000, 4'b1011, 0);
    run_op("sub8",     3'd2, 1'b0, 16'h0010, 16'h0001, 1'b0, 3'd2, 1'b0, 16'h000F, 4'b0110, 5);
    run_op("cp8",      3'd7, 1'b0, 16'h0042, 16'h0042, 1'b0, 3'd2, 1'b0, 16'h0042, 4'b1100, 0);
    run_op("adc8",     3'd1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h0000, 4'b1011, 0);
    run_op("add8_cy",  3'd0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h00FF, 4'b0000, 0);
    run_op("and8",     3'd4, 1'b0, 16'h00F0, 16'h000F, 1'b0, 3'd4, 1'b0, 16'h0000, 4'b1010, 0);
    run_op("add16",    3'd0, 1'b1, 16'h8FFF, 16'h0001, 1'b0, 3'd0, 1'b0, 16'h9000, 4'b0010, 0);
    run_op("sbc8",     3'd3, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd3, 1'b1, 16'h00FF, 4'b0111, 0);
    run_op("xor16",    3'd5, 1'b1, 16'h1234, 16'h1234, 1'b0, 3'd5, 1'b0, 16'h0000, 4'b1000, 0);
    run_op("or8",      3'd6, 1'b0, 16'h000F, 16'h00F0, 1'b0, 3'd6, 1'b0, 16'h00FF, 4'b0000, 0);
    run_op("add8_hi",  3'd0, 1'b0, 16'hAB12, 16'hCD01, 1'b0, 3'd0, 1'b0, 16'h0013, 4'b0000, 0);
    run_op("sub16",    3'd2, 1'b1, 16'h1000, 16'h0001, 1'b0, 3'd2, 1'b0, 16'h0FFF, 4'b0110, 0);
    run_op("cp16",     3'd7, 1'b1, 16'h1234, 16'h2000, 1'b0, 3'd2, 1'b0, 16'h1234, 4'b0101, 0);

    // Abort a 16-bit add with reset while the second nibble is on the core.
    bus.req_op    = 3'd0;
    bus.req_wide  = 1'b1;
    bus.req_a     = 16'h1111;
    bus.req_b     = 16'h2222;
    bus.req_carry = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    check("abort:nib_a1", 32'(nib_a), 32'd1);
    check("abort:nib_op1", 32'(nib_op), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort:req_ready", 32'(bus.req_ready), 32'd1);
    check("abort:nib_a", 32'(nib_a), 32'd0);
    check("abort:nib_op", 32'(nib_op), 32'd0);
    seen = bus.rsp_valid;
    repeat (6) begin
      @(posedge clock); #1;
      seen = seen | bus.rsp_valid;
    end
    check("abort:no_rsp", 32'(seen), 32'd0);
    run_op("post_abort", 3'd0, 1'b0, 16'h0021, 16'h0012, 1'b0, 3'd0, 1'b0, 16'h0033, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
